// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter for the serial system-bus port of the interconnect.
// The grant is held for a whole transaction, with an optional forced release after MAX_HOLD cycles.
module bus_master_arbiter #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic clk,
    input  logic rst,
    // master 1
    input  logic m1_req,
    output logic m1_grant,
    input  logic m1_mode,
    input  logic m1_wr_bus,
    input  logic m1_master_valid,
    input  logic m1_master_ready,
    output logic m1_rd_bus,
    output logic m1_ack,
    output logic m1_slave_ready,
    output logic m1_slave_valid,
    // master 2
    input  logic m2_req,
    output logic m2_grant,
    input  logic m2_mode,
    input  logic m2_wr_bus,
    input  logic m2_master_valid,
    input  logic m2_master_ready,
    output logic m2_rd_bus,
    output logic m2_ack,
    output logic m2_slave_ready,
    output logic m2_slave_valid,
    // interconnect master port
    output logic b_mode,
    output logic b_wr_bus,
    output logic b_master_valid,
    output logic b_master_ready,
    input  logic b_rd_bus,
    input  logic b_ack,
    input  logic b_slave_ready,
    input  logic b_slave_valid,
    // status
    output logic owner,
    output logic timeout
);

    localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_owner;
    logic             w_next_owner;
    logic             r_last_owner;
    logic             r_m1_grant;
    logic             r_m2_grant;
    logic             r_timeout;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_owner_req;
    logic             w_force;
    logic             w_busy;

    // Next-state and arbitration decision.
    always_comb begin
        w_next       = r_state;
        w_next_owner = r_owner;
        w_force      = 1'b0;
        w_owner_req  = r_owner ? m2_req : m1_req;
        case (r_state)
            S_IDLE: begin
                if (m1_req && m2_req) begin
                    w_next       = S_BUSY;
                    w_next_owner = ~r_last_owner;
                end else if (m1_req) begin
                    w_next       = S_BUSY;
                    w_next_owner = 1'b0;
                end else if (m2_req) begin
                    w_next       = S_BUSY;
                    w_next_owner = 1'b1;
                end
            end
            S_BUSY: begin
                // A normal end wins over a coincident hold expiry.
                if (!w_owner_req) begin
                    w_next = S_RELEASE;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)) begin
                    w_next  = S_RELEASE;
                    w_force = 1'b1;
                end
            end
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State, grants, hold counter and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_m1_grant   <= 1'b0;
            r_m2_grant   <= 1'b0;
            r_timeout    <= 1'b0;
            r_hold_cnt   <= '0;
        end else begin
            r_state    <= w_next;
            r_owner    <= w_next_owner;
            r_m1_grant <= (w_next == S_BUSY) && !w_next_owner;
            r_m2_grant <= (w_next == S_BUSY) && w_next_owner;
            r_timeout  <= w_force;
            case (r_state)
                S_BUSY: r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                S_RELEASE: begin
                    r_hold_cnt   <= '0;
                    r_last_owner <= r_owner;
                end
                default: r_hold_cnt <= '0;
            endcase
        end
    end

    assign w_busy = (r_state == S_BUSY);

    // Granted master's serial signals pass straight through; everything else idles at 0.
    assign b_mode         = w_busy & (r_owner ? m2_mode         : m1_mode);
    assign b_wr_bus       = w_busy & (r_owner ? m2_wr_bus       : m1_wr_bus);
    assign b_master_valid = w_busy & (r_owner ? m2_master_valid : m1_master_valid);
    assign b_master_ready = w_busy & (r_owner ? m2_master_ready : m1_master_ready);

    assign m1_rd_bus      = w_busy & !r_owner & b_rd_bus;
    assign m1_ack         = w_busy & !r_owner & b_ack;
    assign m1_slave_ready = w_busy & !r_owner & b_slave_ready;
    assign m1_slave_valid = w_busy & !r_owner & b_slave_valid;
    assign m2_rd_bus      = w_busy & r_owner & b_rd_bus;
    assign m2_ack         = w_busy & r_owner & b_ack;
    assign m2_slave_ready = w_busy & r_owner & b_slave_ready;
    assign m2_slave_valid = w_busy & r_owner & b_slave_valid;

    assign m1_grant = r_m1_grant;
    assign m2_grant = r_m2_grant;
    assign owner    = r_owner;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Testbench for bus_master_arbiter: a fixed vector table, hand-built hold-timeout sequences,
// and random traffic compared against a transaction-level reference model.
module tb_bus_master_arbiter;

    localparam int unsigned MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;
    logic m1_req, m1_grant, m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready;
    logic m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid;
    logic m2_req, m2_grant, m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready;
    logic m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid;
    logic b_mode, b_wr_bus, b_master_valid, b_master_ready;
    logic b_rd_bus, b_ack, b_slave_ready, b_slave_valid;
    logic owner, timeout;

    always #5 clk = ~clk;

    bus_master_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m1_req(m1_req), .m1_grant(m1_grant),
        .m1_mode(m1_mode), .m1_wr_bus(m1_wr_bus),
        .m1_master_valid(m1_master_valid), .m1_master_ready(m1_master_ready),
        .m1_rd_bus(m1_rd_bus), .m1_ack(m1_ack),
        .m1_slave_ready(m1_slave_ready), .m1_slave_valid(m1_slave_valid),
        .m2_req(m2_req), .m2_grant(m2_grant),
        .m2_mode(m2_mode), .m2_wr_bus(m2_wr_bus),
        .m2_master_valid(m2_master_valid), .m2_master_ready(m2_master_ready),
        .m2_rd_bus(m2_rd_bus), .m2_ack(m2_ack),
        .m2_slave_ready(m2_slave_ready), .m2_slave_valid(m2_slave_valid),
        .b_mode(b_mode), .b_wr_bus(b_wr_bus),
        .b_master_valid(b_master_valid), .b_master_ready(b_master_ready),
        .b_rd_bus(b_rd_bus), .b_ack(b_ack),
        .b_slave_ready(b_slave_ready), .b_slave_valid(b_slave_valid),
        .owner(owner), .timeout(timeout)
    );

    // {m1_grant, m2_grant, owner, timeout, b_* out x4, m1 return x4, m2 return x4}
    logic [15:0] act;
    assign act = {m1_grant, m2_grant, owner, timeout,
                  b_mode, b_wr_bus, b_master_valid, b_master_ready,
                  m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid,
                  m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid};

    typedef struct packed {
        logic       rst;
        logic       r1;
        logic       r2;
        logic [3:0] m1s;   // {mode, wr_bus, master_valid, master_ready}
        logic [3:0] m2s;
        logic [3:0] bret;  // {rd_bus, ack, slave_ready, slave_valid}
        logic [1:0] eg;    // {m1_grant, m2_grant}
        logic       eown;
        logic       eto;
        logic [3:0] eb;
        logic [3:0] e1;
        logic [3:0] e2;
    } vec_t;

    vec_t tbl [18];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Reference model state: current owner (-1 none), cycles held, idle gap left.
    int   mo;
    int   held;
    int   cool;
    bit   last_m2;
    bit   own_reg;
    bit   to_m;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic q1, input logic q2,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] br);
        rst = r;
        m1_req = q1;
        m2_req = q2;
        {m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready} = s1;
        {m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready} = s2;
        {b_rd_bus, b_ack, b_slave_ready, b_slave_valid} = br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        mo = -1; held = 0; cool = 0; last_m2 = 1'b1; own_reg = 1'b0; to_m = 1'b0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs present at that edge.
    task automatic model_step();
        bit req;
        if (rst) begin
            model_reset();
        end else if (mo >= 0) begin
            req = (mo == 0) ? m1_req : m2_req;
            if (!req || (MAX_HOLD != 0 && held == int'(MAX_HOLD))) begin
                to_m    = req;
                last_m2 = (mo == 1);
                mo      = -1;
                cool    = 1;
            end else begin
                held++;
                to_m = 1'b0;
            end
        end else if (cool > 0) begin
            cool--;
            to_m = 1'b0;
        end else begin
            to_m = 1'b0;
            if (m1_req && m2_req) mo = last_m2 ? 0 : 1;
            else if (m1_req)      mo = 0;
            else if (m2_req)      mo = 1;
            if (mo >= 0) begin
                held    = 1;
                own_reg = (mo == 1);
            end
        end
    endtask

    function automatic logic [15:0] model_exp();
        logic [3:0] s1, s2, br, eb;
        s1 = {m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready};
        s2 = {m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready};
        br = {b_rd_bus, b_ack, b_slave_ready, b_slave_valid};
        eb = (mo == 0) ? s1 : ((mo == 1) ? s2 : 4'h0);
        return {mo == 0, mo == 1, own_reg, to_m, eb,
                (mo == 0) ? br : 4'h0, (mo == 1) ? br : 4'h0};
    endfunction

    initial begin
        //          rst  r1    r2    m1s   m2s   bret  eg     own   to    eb    e1    e2
        tbl[0]  = '{1'b0,1'b1,1'b0, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0,1'b1,1'b0, 4'h4, 4'hF, 4'h4, 2'b10, 1'b0, 1'b0, 4'h4, 4'h4, 4'h0};
        tbl[2]  = '{1'b0,1'b1,1'b1, 4'hA, 4'h5, 4'hB, 2'b10, 1'b0, 1'b0, 4'hA, 4'hB, 4'h0};
        tbl[3]  = '{1'b0,1'b0,1'b1, 4'hF, 4'hF, 4'hF, 2'b10, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0};
        tbl[4]  = '{1'b0,1'b0,1'b1, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[5]  = '{1'b0,1'b0,1'b1, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[6]  = '{1'b0,1'b1,1'b1, 4'hC, 4'h3, 4'hC, 2'b01, 1'b1, 1'b0, 4'h3, 4'h0, 4'hC};
        tbl[7]  = '{1'b0,1'b1,1'b0, 4'hF, 4'h9, 4'h6, 2'b01, 1'b1, 1'b0, 4'h9, 4'h0, 4'h6};
        tbl[8]  = '{1'b0,1'b1,1'b0, 4'hF, 4'hF, 4'hF, 2'b00, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{1'b0,1'b1,1'b0, 4'hF, 4'hF, 4'hF, 2'b00, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[10] = '{1'b0,1'b1,1'b0, 4'h1, 4'hF, 4'h1, 2'b10, 1'b0, 1'b0, 4'h1, 4'h1, 4'h0};
        tbl[11] = '{1'b1,1'b1,1'b1, 4'hF, 4'hF, 4'hF, 2'b10, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0};
        tbl[12] = '{1'b0,1'b1,1'b1, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{1'b0,1'b1,1'b1, 4'h6, 4'hF, 4'h9, 2'b10, 1'b0, 1'b0, 4'h6, 4'h9, 4'h0};
        tbl[14] = '{1'b0,1'b0,1'b1, 4'hF, 4'hF, 4'hF, 2'b10, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0};
        tbl[15] = '{1'b0,1'b0,1'b1, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[16] = '{1'b0,1'b0,1'b1, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[17] = '{1'b0,1'b0,1'b1, 4'h0, 4'h5, 4'hA, 2'b01, 1'b1, 1'b0, 4'h5, 4'h0, 4'hA};

        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        do_reset();

        // Table: one row per cycle, inputs at the falling edge, outputs checked just after.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].r1, tbl[i].r2, tbl[i].m1s, tbl[i].m2s, tbl[i].bret);
            #1;
            check($sformatf("vec%0d", i), act,
                  {tbl[i].eg, tbl[i].eown, tbl[i].eto, tbl[i].eb, tbl[i].e1, tbl[i].e2});
        end

        // Forced release: M1 holds for MAX_HOLD cycles, then M2 gets the bus.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < int'(MAX_HOLD); i++) begin
            @(negedge clk); #1;
            check($sformatf("hold%0d", i), 16'({m1_grant, m2_grant, timeout}), 16'(3'b100));
        end
        @(negedge clk); #1;
        check("forced_release", 16'({m1_grant, m2_grant, timeout}), 16'(3'b001));
        @(negedge clk); #1;
        check("idle_after_force", 16'({m1_grant, m2_grant, timeout}), 16'(3'b000));
        @(negedge clk); #1;
        check("m2_after_force", 16'({m1_grant, m2_grant, owner, timeout}), 16'(4'b0110));

        // Normal end in the final allowed cycle raises no timeout pulse.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < int'(MAX_HOLD); i++) begin
            @(negedge clk); #1;
            check($sformatf("edge_hold%0d", i), 16'(m1_grant), 16'(1'b1));
        end
        m1_req = 1'b0;
        @(negedge clk); #1;
        check("normal_at_limit", 16'({m1_grant, m2_grant, timeout}), 16'(3'b000));

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
            if ($urandom_range(0, 7) == 0) m2_req = ~m2_req;
            {m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready} = 4'($urandom);
            {m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready} = 4'($urandom);
            {b_rd_bus, b_ack, b_slave_ready, b_slave_valid} = 4'($urandom);
            #1;
            check($sformatf("rand%0d", i), act, model_exp());
            @(posedge clk);
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares the single serial system-bus port of the address-decoding interconnect between two masters, M1 and M2.
- Uses request/grant arbitration with round-robin priority on simultaneous requests.
- The grant is held for the whole transaction. An optional hold timeout force-releases a master that holds the bus too long.
- Sits between the masters and the interconnect's master-side port. The granted master's serial signals pass through combinationally; the other master sees an idle bus.

Parameters:
- MAX_HOLD, 64, maximum cycles a grant may be held in BUSY before forced release; 0 disables the timeout.
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- m1_req  in  1  M1 requests bus ownership; held high for the whole transaction
- m1_grant  out  1  M1 owns the bus (registered)
- m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready  in  1 each  M1 serial bus outputs
- m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid  out  1 each  bus return path to M1
- m2_req, m2_grant, m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready, m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid  same as M1
- b_mode, b_wr_bus, b_master_valid, b_master_ready  out  1 each  to interconnect master port
- b_rd_bus, b_ack, b_slave_ready, b_slave_valid  in  1 each  from interconnect master port
- owner  out  1  0 = M1, 1 = M2; meaningful only while a grant is high
- timeout  out  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE.
  - m1_grant = m2_grant = 0, owner = 0, timeout = 0, hold_cnt = 0.
  - last_owner = M2, so M1 wins the first tie.
  - All b_* outputs and all m*_ return outputs are 0.
  - Reset mid-transaction aborts immediately; the bus is idle from the next cycle.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the master that is not last_owner.
  - On a grant: next = BUSY; the grant and owner are registered, so the grant is visible one cycle after req is first sampled.
  - With no req, remain in IDLE.
- BUSY:
  - Outputs are combinational from the owner: b_mode/b_wr_bus/b_master_valid/b_master_ready = owner's inputs.
  - The owner's rd_bus/ack/slave_ready/slave_valid = the matching b_* inputs.
  - The non-owner's return outputs are forced to 0.
  - hold_cnt increments every cycle.
- BUSY -> RELEASE when either:
  - the owner's req is low (normal end), or
  - MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 while req is still high (forced release; timeout = 1 in the following cycle only).
  - Normal release has priority when both conditions hold in the same cycle; no timeout pulse is raised then.
- RELEASE:
  - Lasts one cycle. Both grants are 0, all b_* outputs are 0 and all return outputs are 0.
  - last_owner <= owner, hold_cnt <= 0, next = IDLE.
  - This gives the interconnect a guaranteed idle cycle to clear its address and count registers.
- Back-to-back: a master that keeps req high after release is re-granted no earlier than 2 cycles (RELEASE plus IDLE) with its grant low. If the other master is also requesting, the other master wins.
- A req asserted by the non-owner during BUSY is ignored until IDLE; it causes no glitch on any output.
- Grants are one-hot or zero at all times; m1_grant and m2_grant are never both 1.
- A forced-release master must drop req. If it keeps req high, it competes again under round-robin like any other requester.
- Outside BUSY, all b_* outputs are 0 regardless of the master inputs.

Test Plan:
- Reset then m1_req=1 at cycle 0 -> m1_grant=1 from cycle 1, owner=0; m1_wr_bus toggles appear on b_wr_bus in the same cycle; b_ack=1 returns on m1_ack; m2_ack=0.
- m1_req and m2_req both rise in the same cycle after reset -> M1 granted. M1 drops req 10 cycles later -> RELEASE: both grants 0 and b_master_valid=0 for 1 cycle, then IDLE for 1 cycle, then m2_grant=1 with owner=1.
- M2 requests continuously while M1 repeats 3 transactions -> grants alternate M1, M2, M1, M2; neither master is granted twice in a row while the other waits.
- MAX_HOLD=8, m1_req held high -> m1_grant high for exactly 8 cycles, then timeout=1 for one cycle with m1_grant=0. With m2_req high, M2 is granted next.
- rst=1 asserted mid-BUSY while b_master_valid=1 -> at the next edge all grants, b_* outputs, owner and timeout are 0. After rst drops with both reqs high, M1 wins.
- m2 inputs toggled randomly while M1 owns the bus -> b_* outputs match M1's inputs exactly; all m2_ return outputs are constantly 0.
